sdram_frame_reader: RTL

//  Avalon-MM burst-read master on the FPGA-to-HPS SDRAM port (64-bit data, 29-bit word address).

---
 rtl/sdram_frame_reader_if.sv | 11 +
 rtl/sdram_frame_reader.sv | 111 +++++++++++
 2 files changed

// File: rtl/sdram_frame_reader_if.sv
// sdram_frame_reader_if: Avalon-MM burst-read bus between the frame reader and the SDRAM port
interface sdram_frame_reader_if;
  logic [28:0] address;
  logic [7:0]  burstcount;
  logic        read;
  logic        waitrequest;
  logic [63:0] readdata;
  logic        readdatavalid;
  modport master (output address, burstcount, read, input waitrequest, readdata, readdatavalid);
  modport slave  (input address, burstcount, read, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/sdram_frame_reader.sv
// sdram_frame_reader: burst-reads one frame from SDRAM into a show-ahead FIFO and streams it out; SDRAM_FRAME_READER_UNDERFLOW_COUNT_EN adds an underflow counter on debug_value1
module sdram_frame_reader #(
  parameter int FRAME_WORDS = 192000,
  parameter int BURST_LEN   = 32,
  parameter int FIFO_AW     = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 frame_start,
  input  logic [28:0]          base_address,
  output logic                 frame_done,
  sdram_frame_reader_if.master avm,
  output logic [63:0]          pixel_data,
  output logic                 pixel_valid,
  input  logic                 pixel_ready,
  output logic [31:0]          debug_value0,
  output logic [31:0]          debug_value1
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;
  state_t       r_state, w_nstate;
  logic [28:0]  r_base, r_address;
  logic [7:0]   r_burstcount, w_bc;
  logic         r_read, r_frame_done, w_done;
  logic [31:0]  r_requested, w_req_next, w_remain;
  logic [CW-1:0] r_outstanding, w_out_next, r_count;
  logic [CW:0]  w_space;
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [63:0]  r_mem [DEPTH];
  logic         w_accept, w_push, w_pop, w_start, w_issue;
  assign w_accept   = r_read & ~avm.waitrequest;
  assign w_push     = avm.readdatavalid & (r_state != IDLE);
  assign w_pop      = pixel_valid & pixel_ready;
  assign w_start    = frame_start & (r_state == IDLE);
  assign w_space    = (CW+1)'(DEPTH) - (CW+1)'(r_count) - (CW+1)'(r_outstanding);
  assign w_issue    = (r_state == ISSUE) & ~r_read & (w_space >= (CW+1)'(BURST_LEN));
  assign w_remain   = 32'(FRAME_WORDS) - r_requested;
  assign w_bc       = (w_remain < 32'(BURST_LEN)) ? w_remain[7:0] : 8'(BURST_LEN);
  assign w_req_next = r_requested + (w_accept ? 32'(r_burstcount) : 32'd0);
  assign w_out_next = r_outstanding + (w_accept ? CW'(r_burstcount) : CW'(0)) - CW'(w_push);
  // Next state: start from IDLE, drain once every word is requested, finish when nothing is outstanding
  always_comb begin
    w_done   = (r_state == DRAIN) && (w_out_next == '0);
    w_nstate = w_start ? ISSUE :
               ((r_state == ISSUE) && w_accept && (w_req_next == 32'(FRAME_WORDS))) ? DRAIN :
               w_done ? IDLE : r_state;
  end
  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_nstate;
  end
  // Request generation, burst bookkeeping and FIFO pointers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_base        <= '0;
      r_address     <= '0;
      r_burstcount  <= '0;
      r_read        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_requested   <= '0;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_frame_done <= w_done;
      if (w_start) begin
        r_base        <= base_address;
        r_requested   <= '0;
        r_outstanding <= '0;
      end else begin
        r_requested   <= w_req_next;
        r_outstanding <= w_out_next;
      end
      if (w_accept) r_read <= 1'b0;
      else if (w_issue) begin
        r_read       <= 1'b1;
        r_address    <= r_base + r_requested[28:0];
        r_burstcount <= w_bc;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_wptr  <= r_wptr + FIFO_AW'(w_push);
      r_rptr  <= r_rptr + FIFO_AW'(w_pop);
    end
  end
  // FIFO storage; space is reserved before each burst so a push never lands on a full FIFO
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= avm.readdata;
  end
  assign avm.address    = r_address;
  assign avm.burstcount = r_burstcount;
  assign avm.read       = r_read;
  assign frame_done     = r_frame_done;
  assign pixel_valid    = r_count != '0;
  assign pixel_data     = pixel_valid ? r_mem[r_rptr] : 64'h0;
  assign debug_value0   = {r_state, 2'b00, 12'(r_outstanding), 16'(r_count)};
`ifdef SDRAM_FRAME_READER_UNDERFLOW_COUNT_EN
  logic [15:0] r_uf;
  // Saturating count of cycles the consumer wanted data that was not there during a frame
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_uf <= '0;
    else if (w_start) r_uf <= '0;
    else if ((r_state != IDLE) && pixel_ready && !pixel_valid && (r_uf != 16'hFFFF)) r_uf <= r_uf + 16'd1;
  end
  assign debug_value1 = {16'h0, r_uf};
`else
  assign debug_value1 = 32'h0;
`endif
endmodule
